// File: rtl/dma_copy.sv
// Word-granular DMA engine: copies len words from src to dst, two cycles per word.
// Optional fill mode (writes fill_value len times, one cycle per word) is built when DMA_FILL_EN is defined.
module dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             fill,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             ram_ce_o,
    output logic             ram_we_o,
    output logic [31:0]      ram_addr_o,
    output logic [3:0]       ram_sel_o,
    output logic [31:0]      ram_data_o,
    input  logic [31:0]      ram_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic [31:0]      fval_q, fval_d;

    logic             fill_sel;
    logic [31:0]      fval_in;

`ifdef DMA_FILL_EN
    assign fill_sel = fill;
    assign fval_in  = fill_value;
`else
    // Fill ports stay on the boundary but are inert in copy-only builds.
    logic unused_fill;
    assign unused_fill = ^{fill, fill_value};
    assign fill_sel    = 1'b0;
    assign fval_in     = 32'h0;
`endif

    assign busy = (state_q != IDLE);

    // Next-state, datapath updates and RAM bus drive; bus idles at all-zero.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        fval_d     = fval_q;
        done       = 1'b0;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'h0;
        ram_sel_o  = 4'h0;
        ram_data_o = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = {src_addr[31:2], 2'b00};
                    dst_d  = {dst_addr[31:2], 2'b00};
                    cnt_d  = len;
                    fill_d = fill_sel;
                    fval_d = fval_in;
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (fill_sel) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                ram_ce_o   = 1'b1;
                ram_sel_o  = 4'hF;
                ram_addr_o = src_q;
                buf_d      = ram_data_i;
                state_d    = WRITE;
            end
            WRITE: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_sel_o  = 4'hF;
                ram_addr_o = dst_q;
                ram_data_o = fill_q ? fval_q : buf_q;
                src_d      = src_q + 32'd4;
                dst_d      = dst_q + 32'd4;
                cnt_d      = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else if (fill_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            buf_q   <= 32'h0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            fval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            fval_q  <= fval_d;
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: vector table plus reset, held-start and fill sequences.
// Fill expectations follow DMA_FILL_EN as compiled.
module tb_dma_copy;

`ifdef DMA_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        fill;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    dma_copy #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill       (fill),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_sel_o  (ram_sel_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem   [1024];
    logic [31:0] model [1024];
    logic        init_pend;
    int          init_seed;
    int          wr_cnt;
    int          rd_cnt;
    int          done_cnt;
    int          sel_bad;
    int          idle_bad;
    logic [31:0] first_rd;
    logic [31:0] last_rd;
    logic [31:0] first_wr;
    int          tests;
    int          fails;

    function automatic logic [31:0] init_word(input int i, input int seed);
        logic [31:0] iv;
        logic [31:0] sv;
        iv = i;
        sv = seed;
        if (i >= 64 && i < 68) begin
            init_word = (iv - 32'd63) * 32'd11;
        end else begin
            init_word = {sv[7:0], 8'h5A, 6'd0, iv[9:0]};
        end
    endfunction

    assign ram_data_i = (ram_ce_o && !ram_we_o) ? mem[ram_addr_o[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (init_pend) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i, init_seed);
            wr_cnt   <= 0;
            rd_cnt   <= 0;
            done_cnt <= 0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (ram_ce_o) begin
                if (ram_sel_o != 4'hF) sel_bad <= sel_bad + 1;
                if (ram_we_o) begin
                    mem[ram_addr_o[11:2]] <= ram_data_o;
                    if (wr_cnt == 0) first_wr <= ram_addr_o;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    if (rd_cnt == 0) first_rd <= ram_addr_o;
                    last_rd <= ram_addr_o;
                    rd_cnt  <= rd_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!ram_ce_o && (ram_we_o || ram_addr_o != 0 ||
                          ram_sel_o != 0 || ram_data_o != 0))
            idle_bad <= idle_bad + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic init_mem(input int seed);
        init_seed = seed;
        for (int i = 0; i < 1024; i++) model[i] = init_word(i, seed);
        init_pend = 1'b1;
        @(posedge clk);
        #1 init_pend = 1'b0;
    endtask

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                              input int n, input logic f, input logic [31:0] fv);
        logic [31:0] sa;
        logic [31:0] da;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        for (int k = 0; k < n; k++) begin
            model[da[11:2]] = f ? fv : model[sa[11:2]];
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== model[i]) n++;
        return n;
    endfunction

    task automatic wait_done(output int lat, output int bcyc);
        lat  = -1;
        bcyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_xfer(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic f,
                           input logic [31:0] fv, output int lat, output int bcyc);
        @(negedge clk);
        start      = 1'b1;
        src_addr   = s;
        dst_addr   = d;
        len        = n;
        fill       = f;
        fill_value = fv;
        @(posedge clk);
        #1;
        start      = 1'b0;
        src_addr   = 32'hDEAD_0000;
        dst_addr   = 32'h0000_0BAD;
        len        = 16'd5;
        fill       = ~f;
        fill_value = 32'h1234_5678;
        wait_done(lat, bcyc);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          lat;
        logic [31:0] rd0;
        logic [31:0] rdl;
        logic [31:0] wr0;
    } vec_t;

    vec_t vt [5];

    initial begin
        int lat;
        int bc;
        logic [31:0] exp_v;

        tests = 0; fails = 0;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        sel_bad = 0; idle_bad = 0;
        first_rd = 0; last_rd = 0; first_wr = 0;
        init_pend = 1'b0; init_seed = 0;
        rst = 1'b0; start = 1'b0; fill = 1'b0;
        src_addr = 0; dst_addr = 0; len = 0; fill_value = 0;

        vt[0] = '{32'h100, 32'h200, 16'd4, 9, 32'h100, 32'h10C, 32'h200};
        vt[1] = '{32'h103, 32'h202, 16'd1, 3, 32'h100, 32'h100, 32'h200};
        vt[2] = '{32'h040, 32'h080, 16'd0, 1, 32'h0, 32'h0, 32'h0};
        vt[3] = '{32'hFFFF_FFFC, 32'h400, 16'd2, 5, 32'hFFFF_FFFC, 32'h0, 32'h400};
        vt[4] = '{32'h500, 32'h504, 16'd3, 7, 32'h500, 32'h508, 32'h504};

        init_mem(0);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", ram_ce_o, 0);
        chk("rst_we", ram_we_o, 0);
        chk("rst_addr", ram_addr_o, 0);
        chk("rst_sel", ram_sel_o, 0);
        chk("rst_data", ram_data_o, 0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            init_mem(i + 1);
            model_copy(vt[i].src, vt[i].dst, vt[i].len, 1'b0, 32'h0);
            do_xfer(vt[i].src, vt[i].dst, vt[i].len, 1'b0, 32'h0, lat, bc);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_busy", i), bc, vt[i].lat);
            chk($sformatf("v%0d_wr", i), wr_cnt, vt[i].len);
            chk($sformatf("v%0d_rd", i), rd_cnt, vt[i].len);
            chk($sformatf("v%0d_done", i), done_cnt, 1);
            chk($sformatf("v%0d_mem", i), mem_diff(), 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
            if (vt[i].len != 0) begin
                chk($sformatf("v%0d_rd0", i), first_rd, vt[i].rd0);
                chk($sformatf("v%0d_rdl", i), last_rd, vt[i].rdl);
                chk($sformatf("v%0d_wr0", i), first_wr, vt[i].wr0);
            end
            if (i == 0) begin
                chk("w200", mem[32'h80], 32'd11);
                chk("w204", mem[32'h81], 32'd22);
                chk("w208", mem[32'h82], 32'd33);
                chk("w20C", mem[32'h83], 32'd44);
            end
        end

        // Reset during the second word's write cycle.
        init_mem(20);
        @(negedge clk);
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len = 16'd4;
        fill = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ab_we", ram_we_o, 1);
        chk("ab_addr", ram_addr_o, 32'h204);
        rst = 1'b0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_ce", ram_ce_o, 0);
        chk("ab_addr0", ram_addr_o, 0);
        chk("ab_data0", ram_data_o, 0);
        repeat (3) @(negedge clk);
        chk("ab_done", done_cnt, 0);
        chk("ab_wr", wr_cnt, 1);
        model_copy(32'h100, 32'h200, 1, 1'b0, 32'h0);
        chk("ab_mem", mem_diff(), 0);
        init_mem(21);
        rst = 1'b1;
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h700; len = 16'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        chk("rs_lat", lat, 5);
        chk("rs_busy", bc, 5);
        @(negedge clk);
        model_copy(32'h100, 32'h700, 2, 1'b0, 32'h0);
        chk("rs_mem", mem_diff(), 0);
        chk("rs_done", done_cnt, 1);

        // Start held and re-pulsed during a transfer.
        init_mem(22);
        @(negedge clk);
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h600; len = 16'd2;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (c == 2) begin
                start = 1'b0; len = 16'd7; src_addr = 32'h0;
            end
            if (c == 3) start = 1'b1;
        end
        start = 1'b0;
        chk("hd_lat", lat, 5);
        @(negedge clk);
        chk("hd_idle", busy, 0);
        chk("hd_wr", wr_cnt, 2);
        chk("hd_done", done_cnt, 1);
        model_copy(32'h100, 32'h600, 2, 1'b0, 32'h0);
        chk("hd_mem", mem_diff(), 0);
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h680; len = 16'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        chk("hd2_lat", lat, 3);
        @(negedge clk);
        model_copy(32'h100, 32'h680, 1, 1'b0, 32'h0);
        chk("hd2_mem", mem_diff(), 0);

        // Fill request; behaves as a copy when fill is not built in.
        init_mem(23);
        model_copy(32'h100, 32'h300, 3, FILL_ON, 32'hDEAD_BEEF);
        do_xfer(32'h100, 32'h300, 16'd3, 1'b1, 32'hDEAD_BEEF, lat, bc);
        chk("fl_lat", lat, FILL_ON ? 4 : 7);
        chk("fl_rd", rd_cnt, FILL_ON ? 0 : 3);
        chk("fl_wr", wr_cnt, 3);
        exp_v = FILL_ON ? 32'hDEAD_BEEF : 32'd11;
        chk("fl_w300", mem[32'hC0], exp_v);
        chk("fl_mem", mem_diff(), 0);

        chk("sel_bad", sel_bad, 0);
        chk("idle_bus", idle_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
